// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, mult/div handshake with timeout, branch squash, stall counter.
// Optional build macro SW_DATA_BYPASS_EN: store data register hazards are covered by the M->W bypass.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             br_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_en,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic             md_busy,
  output logic             md_result_valid,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} md_state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [5:0] TO_LAST  = 6'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_t   state;
  md_state_t   state_nxt;
  logic [5:0]  wait_cnt;
  logic [5:0]  wait_cnt_nxt;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       fd_sw, src2_valid;
  logic [4:0] fd_src2;
  logic       dx_mul, dx_div, dx_md;
  logic       match_src1, match_src2, load_use;
  logic       unused_bits;

  assign fd_op    = fd_insn[31:27];
  assign fd_rd    = fd_insn[26:22];
  assign fd_rs    = fd_insn[21:17];
  assign fd_rt    = fd_insn[16:12];
  assign dx_op    = dx_insn[31:27];
  assign dx_rd    = dx_insn[26:22];
  assign dx_aluop = dx_insn[6:2];
  assign unused_bits = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

  assign fd_sw      = (fd_op == OP_SW);
  assign src2_valid = (fd_op == OP_RTYPE) | fd_sw | (fd_op == OP_BNE) | (fd_op == OP_BLT);
  assign fd_src2    = (fd_op == OP_RTYPE) ? fd_rt : fd_rd;

  assign dx_mul = (dx_op == OP_RTYPE) & (dx_aluop == ALU_MUL);
  assign dx_div = (dx_op == OP_RTYPE) & (dx_aluop == ALU_DIV);
  assign dx_md  = dx_mul | dx_div;

  assign match_src1 = (dx_op == OP_LW) & (dx_rd != 5'd0) & (dx_rd == fd_rs);
  assign match_src2 = (dx_op == OP_LW) & (dx_rd != 5'd0) & src2_valid & (dx_rd == fd_src2);

`ifdef SW_DATA_BYPASS_EN
  // A store whose only conflict is its data register gets the value from the M->W bypass.
  assign load_use = match_src1 | (match_src2 & ~fd_sw);
`else
  assign load_use = match_src1 | match_src2;
`endif

  // State register and mult/div wait counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 6'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and pipeline enable decode; reset forces every output to its idle value.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    pc_en           = 1'b1;
    fd_en           = 1'b1;
    xm_en           = 1'b1;
    fd_flush        = 1'b0;
    dx_bubble       = 1'b0;
    md_ctrl_mult    = 1'b0;
    md_ctrl_div     = 1'b0;
    md_busy         = 1'b0;
    md_result_valid = 1'b0;
    md_timeout      = 1'b0;
    if (!reset) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dx_md) begin
            md_ctrl_mult = dx_mul;
            md_ctrl_div  = dx_div;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            xm_en        = 1'b0;
            state_nxt    = WAIT;
            wait_cnt_nxt = 6'd0;
          end else if (br_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        WAIT: begin
          // Branches cannot legally resolve while execute is held, so br_taken is ignored here.
          if (md_ready) begin
            md_result_valid = 1'b1;
            state_nxt       = IDLE;
          end else if (wait_cnt == TO_LAST) begin
            md_busy    = 1'b1;
            md_timeout = 1'b1;
            state_nxt  = IDLE;
          end else begin
            md_busy      = 1'b1;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            xm_en        = 1'b0;
            wait_cnt_nxt = wait_cnt + 6'd1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 6'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: reset, load-use, mult/div ready/timeout, branch squash, store bypass.
module tb_hazard_stall_ctrl;

  localparam int MDT = 40;
`ifdef SW_DATA_BYPASS_EN
  localparam int SW_STALL = 0;
`else
  localparam int SW_STALL = 1;
`endif

  logic        clock, reset, br_taken, md_ready;
  logic [31:0] fd_insn, dx_insn;
  logic        pc_en, fd_en, fd_flush, dx_bubble, xm_en;
  logic        md_ctrl_mult, md_ctrl_div, md_busy, md_result_valid, md_timeout;
  logic [31:0] stall_cycles;
  logic        s_pc_en, s_fd_en, s_fd_flush, s_dx_bubble, s_xm_en;
  logic        s_mult, s_div, s_busy, s_rv, s_to;
  logic [2:0]  s_stall;

  int vectors = 0;
  int miscompares = 0;
  int exp_stall = 0;

  hazard_stall_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .br_taken(br_taken), .md_ready(md_ready), .pc_en(pc_en), .fd_en(fd_en),
    .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_en(xm_en),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_busy(md_busy),
    .md_result_valid(md_result_valid), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  // Narrow counter copy sharing all inputs, used to reach saturation quickly.
  hazard_stall_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(3)) sat (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .br_taken(br_taken), .md_ready(md_ready), .pc_en(s_pc_en), .fd_en(s_fd_en),
    .fd_flush(s_fd_flush), .dx_bubble(s_dx_bubble), .xm_en(s_xm_en),
    .md_ctrl_mult(s_mult), .md_ctrl_div(s_div), .md_busy(s_busy),
    .md_result_valid(s_rv), .md_timeout(s_to), .stall_cycles(s_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic [31:0] nop, mul3, div3, lw5, lw0, lw4;

  initial begin
    nop  = 32'd0;
    mul3 = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
    div3 = rtype(5'd3, 5'd1, 5'd2, 5'b00111);
    lw5  = itype(5'b01000, 5'd5, 5'd1);
    lw0  = itype(5'b01000, 5'd0, 5'd1);
    lw4  = itype(5'b01000, 5'd4, 5'd1);

    // 1: reset with a mul sitting in D/X
    reset = 1'b0; br_taken = 1'b0; md_ready = 1'b0; fd_insn = nop; dx_insn = mul3;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_mult", md_ctrl_mult, 1'b0);
      chk("rst_pc_en", pc_en, 1'b1);
      chk("rst_xm_en", xm_en, 1'b1);
      chk("rst_stall", stall_cycles, 0);
      tick();
    end
    reset = 1'b1; settle();
    chk("start_mult", md_ctrl_mult, 1'b1);
    chk("start_div", md_ctrl_div, 1'b0);
    chk("start_pc_en", pc_en, 1'b0);
    chk("start_xm_en", xm_en, 1'b0);
    chk("start_bubble", dx_bubble, 1'b0);
    tick(); exp_stall = 1; settle();
    chk("wait_mult_pulse", md_ctrl_mult, 1'b0);
    chk("wait_busy", md_busy, 1'b1);
    tick(); exp_stall = 2;
    md_ready = 1'b1; settle();
    chk("ready_rv", md_result_valid, 1'b1);
    chk("ready_pc_en", pc_en, 1'b1);
    chk("ready_xm_en", xm_en, 1'b1);
    tick();
    md_ready = 1'b0; dx_insn = nop; settle();
    chk("t1_stall", stall_cycles, exp_stall);
    chk("idle_busy", md_busy, 1'b0);

    // 2: load-use on rs, rd=r0, rt, non-source rd, bne rd
    dx_insn = lw5; fd_insn = rtype(5'd6, 5'd5, 5'd2, 5'd0); settle();
    chk("lu_pc_en", pc_en, 1'b0);
    chk("lu_fd_en", fd_en, 1'b0);
    chk("lu_bubble", dx_bubble, 1'b1);
    chk("lu_flush", fd_flush, 1'b0);
    tick(); exp_stall++;
    dx_insn = nop; settle();
    chk("lu_release", pc_en, 1'b1);
    chk("lu_stall", stall_cycles, exp_stall);
    tick();
    dx_insn = lw0; fd_insn = rtype(5'd6, 5'd0, 5'd2, 5'd0); settle();
    chk("lu_r0_pc_en", pc_en, 1'b1);
    chk("lu_r0_bubble", dx_bubble, 1'b0);
    tick();
    dx_insn = lw5; fd_insn = rtype(5'd6, 5'd2, 5'd5, 5'd0); settle();
    chk("lu_rt_pc_en", pc_en, 1'b0);
    tick(); exp_stall++;
    fd_insn = itype(5'b00101, 5'd5, 5'd1); settle();
    chk("lu_itype_rd", pc_en, 1'b1);
    tick();
    fd_insn = itype(5'b00010, 5'd5, 5'd1); settle();
    chk("lu_bne_rd", pc_en, 1'b0);
    tick(); exp_stall++;
    dx_insn = nop; fd_insn = nop; settle();
    chk("t2_stall", stall_cycles, exp_stall);
    chk("t2_sat_stall", s_stall, 3'd5);

    // 3: divide with ready after 32 wait cycles, then back-to-back mul
    dx_insn = div3; settle();
    chk("div_start", md_ctrl_div, 1'b1);
    chk("div_no_mult", md_ctrl_mult, 1'b0);
    tick(); exp_stall++;
    for (int i = 0; i < 32; i++) begin
      settle();
      chk("div_busy", md_busy, 1'b1);
      chk("div_pc_hold", pc_en, 1'b0);
      chk("div_no_rv", md_result_valid, 1'b0);
      tick(); exp_stall++;
    end
    md_ready = 1'b1; settle();
    chk("div_rv", md_result_valid, 1'b1);
    chk("div_busy_end", md_busy, 1'b0);
    chk("div_pc_en", pc_en, 1'b1);
    tick();
    md_ready = 1'b0; dx_insn = mul3; settle();
    chk("div_stall", stall_cycles, exp_stall);
    chk("b2b_mult", md_ctrl_mult, 1'b1);
    tick(); exp_stall++;

    // 4: mul with no ready -> timeout on the MDT-th wait cycle
    for (int i = 0; i < MDT - 1; i++) begin
      settle();
      chk("to_early", md_timeout, 1'b0);
      chk("to_hold", pc_en, 1'b0);
      tick(); exp_stall++;
    end
    settle();
    chk("to_pulse", md_timeout, 1'b1);
    chk("to_pc_en", pc_en, 1'b1);
    chk("to_rv", md_result_valid, 1'b0);
    tick();
    dx_insn = nop; settle();
    chk("to_done", md_timeout, 1'b0);
    chk("to_stall", stall_cycles, exp_stall);

    // 5: branch beats load-use; branch ignored in WAIT
    dx_insn = lw5; fd_insn = rtype(5'd6, 5'd5, 5'd2, 5'd0); br_taken = 1'b1; settle();
    chk("br_flush", fd_flush, 1'b1);
    chk("br_bubble", dx_bubble, 1'b1);
    chk("br_pc_en", pc_en, 1'b1);
    tick();
    br_taken = 1'b0; dx_insn = mul3; fd_insn = nop; settle();
    chk("br_stall", stall_cycles, exp_stall);
    tick(); exp_stall++;
    br_taken = 1'b1; settle();
    chk("br_wait_flush", fd_flush, 1'b0);
    chk("br_wait_pc", pc_en, 1'b0);
    tick(); exp_stall++;
    br_taken = 1'b0; md_ready = 1'b1; tick();
    md_ready = 1'b0; dx_insn = nop;

    // 6: store data-register vs base-register hazard
    dx_insn = lw4; fd_insn = itype(5'b00111, 5'd4, 5'd7); settle();
    chk("sw_data_pc_en", pc_en, (SW_STALL == 1) ? 1'b0 : 1'b1);
    tick(); exp_stall += SW_STALL;
    fd_insn = itype(5'b00111, 5'd7, 5'd4); settle();
    chk("sw_base_pc_en", pc_en, 1'b0);
    tick(); exp_stall++;
    dx_insn = nop; fd_insn = nop; settle();
    chk("t6_stall", stall_cycles, exp_stall);
    chk("sat_stall", s_stall, 3'd7);

    // 7: reset asserted mid-WAIT
    dx_insn = mul3; tick(); settle();
    chk("mid_busy", md_busy, 1'b1);
    reset = 1'b0; settle();
    chk("mid_rst_busy", md_busy, 1'b0);
    chk("mid_rst_pc_en", pc_en, 1'b1);
    chk("mid_rst_mult", md_ctrl_mult, 1'b0);
    chk("mid_rst_stall", stall_cycles, 0);
    dx_insn = nop; tick();
    reset = 1'b1; settle();
    chk("post_rst_busy", md_busy, 1'b0);
    chk("post_rst_pc_en", pc_en, 1'b1);
    tick();
    chk("post_rst_stall", stall_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It sits beside the F/D and D/X latches and drives the enables for the PC, F/D, D/X and X/M stages. It detects load-use hazards, runs the multi-cycle mult/div handshake (start pulse, wait for ready, timeout), and squashes wrong-path instructions on a taken branch. It also keeps a stall-cycle performance counter.

Parameters:
MD_TIMEOUT, 40, maximum WAIT cycles before a mult/div is abandoned (1..63)
CNT_W, 32, width of stall_cycles counter

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
fd_insn  input  32  instruction in F/D latch
dx_insn  input  32  instruction in D/X latch
br_taken  input  1  branch/jump resolved taken in execute this cycle
md_ready  input  1  mult/div result valid (single-cycle pulse)
pc_en  output  1  PC register enable
fd_en  output  1  F/D latch enable
fd_flush  output  1  load nop into F/D
dx_bubble  output  1  load nop into D/X
xm_en  output  1  X/M latch enable
md_ctrl_mult  output  1  start multiply (1-cycle pulse)
md_ctrl_div  output  1  start divide (1-cycle pulse)
md_busy  output  1  FSM in WAIT
md_result_valid  output  1  mult/div result captured into X/M this cycle
md_timeout  output  1  1-cycle pulse on abandon
stall_cycles  output  CNT_W  count of cycles with pc_en=0, saturating

Behaviour:
- Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]. mul = opcode 00000 & aluop 00110. div = opcode 00000 & aluop 00111. lw = 01000. sw = 00111. bne = 00010. blt = 00110.
- fd sources: src1 = rs for all opcodes. src2 = rt for R-type. src2 = rd for sw/bne/blt. No src2 otherwise.
- Load-use hazard: dx is lw, dx.rd != 0, and dx.rd equals src1 or src2. Response: pc_en=0, fd_en=0, dx_bubble=1 for exactly 1 cycle.
- FSM states: IDLE, WAIT. The wait counter is 6 bits.
- IDLE, dx is mul/div: assert md_ctrl_mult or md_ctrl_div combinationally for that cycle. Also pc_en=fd_en=xm_en=0 and dx held (no bubble). Next state WAIT, counter cleared.
- WAIT, md_ready=0: md_busy=1, stall held, counter increments.
- WAIT, md_ready=1: md_result_valid=1, xm_en=pc_en=fd_en=1, stall released this cycle. Next state IDLE. The next dx_insn is whatever advances on that edge, so back-to-back mul/div restarts cleanly.
- WAIT, counter reaches MD_TIMEOUT-1 without ready: md_timeout=1, release as on ready but md_result_valid=0, next IDLE.
- md_ready arriving in IDLE: ignored.
- Priority, highest first:
  - mult/div stall: suppresses load-use detection.
  - br_taken: fd_flush=1, dx_bubble=1, pc_en=1, no load-use stall.
  - load-use.
  - br_taken cannot coincide with WAIT; if it does, it is ignored.
- Default (no event): pc_en=fd_en=xm_en=1, all others 0.
- stall_cycles: +1 on each rising edge where pc_en=0. Saturates at all-ones.
- Reset (low, any time including mid-WAIT): state=IDLE, counters=0. All outputs are forced to defaults while low: pc_en=fd_en=xm_en=1, rest 0. No md_ctrl pulse during reset, regardless of dx_insn.

Optional Feature:
SW_DATA_BYPASS_EN:
- Defined: a sw in F/D whose only match with a lw dx.rd is its data register (rd, not rs) does not stall; the M->W bypass supplies the data.
- Undefined: that case stalls 1 cycle like any load-use.

Test Plan:
1. reset low 3 cycles with dx_insn=mul r3,r1,r2 -> md_ctrl_mult=0, pc_en=1, stall_cycles=0. Release reset -> md_ctrl_mult pulses 1 cycle, state WAIT.
2. dx=lw r5,0(r1), fd=add r6,r5,r2 -> 1 cycle pc_en=0, fd_en=0, dx_bubble=1, then pc_en=1. stall_cycles=1. Same with dx.rd=r0 -> no stall.
3. dx=div, md_ready after 32 cycles -> md_busy=1 for 32 cycles, md_result_valid=1 on the ready cycle, stall_cycles=33. Then a back-to-back mul -> new md_ctrl_mult on the following cycle.
4. dx=mul, md_ready never -> md_timeout pulse after MD_TIMEOUT cycles, pc_en returns 1, md_result_valid stays 0.
5. br_taken=1 with a load-use condition present -> fd_flush=1, dx_bubble=1, pc_en=1, stall_cycles unchanged.
6. dx=lw r4, fd=sw r4,0(r7) -> with SW_DATA_BYPASS_EN: no stall. Without it: 1-cycle stall. fd=sw r7,0(r4) -> stall in both builds.
